// File: rtl/sample_queue_pkg.sv
// sample_queue_pkg: width helpers and status struct shared by the queue, its RAM and the serializer
package sample_queue_pkg;
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int cnt_w(input int depth);
    return clog2_safe(depth + 1);
  endfunction
  function automatic int addr_w(input int depth);
    return clog2_safe(depth);
  endfunction
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic ovf;
    logic unf;
  } status_t;
endpackage

// File: rtl/sample_queue_ram.sv
// sample_queue_ram: simple dual-port RAM with synchronous write and synchronous read
module sample_queue_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_sample_queue.sv
// sync_sample_queue: single-clock FWFT sample FIFO with drop, flush, thresholds and sticky error flags
module sync_sample_queue
  import sample_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16384,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_pulse_q, ovf_pulse_d, unf_pulse_q, unf_pulse_d;
  logic ovf_sticky_q, ovf_sticky_d, unf_sticky_q, unf_sticky_d;
  logic byp_q, byp_d;
  logic [WIDTH-1:0] byp_data_q, rdata;
  logic push_ok, pop_ok, we;
  status_t st;
  function automatic logic [ADDR_W-1:0] inc_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + ADDR_W'(1);
  endfunction
  always_comb begin
    pop_ok = pop && !flush && count_q != '0;
    push_ok = push && !flush && (count_q != DEPTH_C || pop_ok);
    ovf_pulse_d = push && !flush && !push_ok;
    unf_pulse_d = pop && !flush && count_q == '0;
    wr_ptr_d = flush ? '0 : push_ok ? inc_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop_ok ? inc_ptr(rd_ptr_q) : rd_ptr_q;
    count_d = flush ? '0 : (push_ok && !pop_ok) ? count_q + CNT_W'(1) : (pop_ok && !push_ok) ? count_q - CNT_W'(1) : count_q;
    ovf_sticky_d = ovf_pulse_d || (ovf_sticky_q && !clr_err);
    unf_sticky_d = unf_pulse_d || (unf_sticky_q && !clr_err);
    we = push_ok && !rst;
    byp_d = we && wr_ptr_q == rd_ptr_d;
  end
  always_ff @(posedge clk) begin
    byp_data_q <= wr_data;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_pulse_q <= 1'b0;
      unf_pulse_q <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_pulse_q <= ovf_pulse_d;
      unf_pulse_q <= unf_pulse_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
      byp_q <= byp_d;
    end
  end
  sample_queue_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_d),
    .rdata(rdata)
  );
  always_comb begin
    st.full = count_q == DEPTH_C;
    st.empty = count_q == '0;
    st.almost_full = AF_LEVEL <= 0 || (AF_LEVEL <= DEPTH && count_q >= AF_C);
    st.almost_empty = AE_LEVEL >= DEPTH || (AE_LEVEL >= 0 && count_q <= AE_C);
    st.ovf = ovf_sticky_q;
    st.unf = unf_sticky_q;
  end
  assign top = byp_q ? byp_data_q : rdata;
  assign count = count_q;
  assign full = st.full;
  assign empty = st.empty;
  assign almost_full = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign ovf_sticky = st.ovf;
  assign unf_sticky = st.unf;
  assign ovf_pulse = ovf_pulse_q;
  assign unf_pulse = unf_pulse_q;
endmodule

// File: tb/tb_sync_sample_queue.sv
// tb_sync_sample_queue: table, directed and random checks of two queue depths against a queue model
module tb_sync_sample_queue;
  logic clk, rst, push, pop, flush, clr_err;
  logic [31:0] wr_data, top16, top5;
  logic [4:0] cnt16;
  logic [2:0] cnt5;
  logic full16, empty16, af16, ae16, op16, up16, os16, us16;
  logic full5, empty5, af5, ae5, op5, up5, os5, us5;
  int errors = 0, checks = 0;
  int mq[2][$];
  bit m_op[2], m_up[2], m_os[2], m_us[2];
  int md[2] = '{16, 5};
  int maf[2] = '{12, 1};
  logic [31:0] a_top[2], a_cnt[2];
  logic [7:0] a_flags[2];
  sync_sample_queue #(.WIDTH(32), .DEPTH(16)) u16 (
    .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop), .flush(flush), .clr_err(clr_err),
    .top(top16), .count(cnt16), .full(full16), .empty(empty16), .almost_full(af16), .almost_empty(ae16),
    .ovf_pulse(op16), .unf_pulse(up16), .ovf_sticky(os16), .unf_sticky(us16)
  );
  sync_sample_queue #(.WIDTH(32), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop), .flush(flush), .clr_err(clr_err),
    .top(top5), .count(cnt5), .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .ovf_pulse(op5), .unf_pulse(up5), .ovf_sticky(os5), .unf_sticky(us5)
  );
  assign a_top[0] = top16;
  assign a_top[1] = top5;
  assign a_cnt[0] = 32'(cnt16);
  assign a_cnt[1] = 32'(cnt5);
  assign a_flags[0] = {full16, empty16, af16, ae16, op16, up16, os16, us16};
  assign a_flags[1] = {full5, empty5, af5, ae5, op5, up5, os5, us5};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic model_step(input bit r, p, o, f, c, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mq[i].delete();
        m_op[i] = 0; m_up[i] = 0; m_os[i] = 0; m_us[i] = 0;
      end else if (f) begin
        mq[i].delete();
        m_op[i] = 0; m_up[i] = 0;
        if (c) begin m_os[i] = 0; m_us[i] = 0; end
      end else begin
        bit pok, uok;
        pok = o && mq[i].size() > 0;
        uok = p && (mq[i].size() < md[i] || pok);
        m_op[i] = p && !uok;
        m_up[i] = o && mq[i].size() == 0;
        if (pok) void'(mq[i].pop_front());
        if (uok) mq[i].push_back(int'(d));
        m_os[i] = m_op[i] || (m_os[i] && !c);
        m_us[i] = m_up[i] || (m_us[i] && !c);
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int n;
      logic [7:0] ef;
      n = mq[i].size();
      ef = {n == md[i], n == 0, n >= maf[i], n <= 4, m_op[i], m_up[i], m_os[i], m_us[i]};
      chk($sformatf("count_d%0d", md[i]), a_cnt[i], 32'(n));
      chk($sformatf("flags_d%0d", md[i]), 32'(a_flags[i]), 32'(ef));
      if (n > 0) chk($sformatf("top_d%0d", md[i]), a_top[i], 32'(mq[i][0]));
    end
    chk("ptr_range_d5", 32'(u5.wr_ptr_q < 3'd5 && u5.rd_ptr_q < 3'd5), 32'd1);
  endtask
  task automatic cyc(input bit r, p, o, f, c, input logic [31:0] d);
    rst = r; push = p; pop = o; flush = f; clr_err = c; wr_data = d;
    @(posedge clk);
    model_step(r, p, o, f, c, d);
    #1;
    check_all();
  endtask
  typedef struct {
    bit p;
    bit o;
    logic [31:0] d;
    int cnt;
    bit full;
    bit af;
    bit ovfp;
    bit emp;
    logic [31:0] top;
  } vec_t;
  vec_t tbl[33];
  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b0, 32'(i + 1), i + 1, i == 15, (i + 1) >= 12, 1'b0, 1'b0, 32'd1};
    tbl[16] = '{1'b1, 1'b0, 32'hDEADBEEF, 16, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1};
    for (int i = 0; i < 16; i++) tbl[17 + i] = '{1'b0, 1'b1, 32'd0, 15 - i, 1'b0, (15 - i) >= 12, 1'b0, i == 15, 32'(i + 2)};
    rst = 1; push = 0; pop = 0; flush = 0; clr_err = 0; wr_data = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 32'h55);
    chk("reset_empty", 32'(empty16), 32'd1);
    chk("reset_ae", 32'(ae16), 32'd1);
    chk("reset_af", 32'(af16), 32'd0);
    for (int k = 0; k < 33; k++) begin
      cyc(0, tbl[k].p, tbl[k].o, 0, 0, tbl[k].d);
      chk($sformatf("tbl%0d_count", k), 32'(cnt16), 32'(tbl[k].cnt));
      chk($sformatf("tbl%0d_full", k), 32'(full16), 32'(tbl[k].full));
      chk($sformatf("tbl%0d_af", k), 32'(af16), 32'(tbl[k].af));
      chk($sformatf("tbl%0d_ovfp", k), 32'(op16), 32'(tbl[k].ovfp));
      chk($sformatf("tbl%0d_empty", k), 32'(empty16), 32'(tbl[k].emp));
      if (!tbl[k].emp) chk($sformatf("tbl%0d_top", k), top16, tbl[k].top);
    end
    chk("ovf_sticky_kept", 32'(os16), 32'd1);
    for (int k = 0; k < 16; k++) cyc(0, 1, 0, 0, 0, 32'h100 + 32'(k));
    cyc(0, 1, 1, 0, 0, 32'h1234);
    chk("full_pushpop_count", 32'(cnt16), 32'd16);
    chk("full_pushpop_no_ovf", 32'(op16), 32'd0);
    chk("full_pushpop_top", top16, 32'h101);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 32'hA5);
    chk("empty_pushpop_unf", 32'(up16), 32'd1);
    chk("empty_pushpop_count", 32'(cnt16), 32'd1);
    chk("empty_pushpop_top", top16, 32'hA5);
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 32'h200 + 32'(k));
    chk("pre_flush_count", 32'(cnt16), 32'd7);
    cyc(0, 1, 0, 1, 0, 32'hFF);
    chk("flush_count", 32'(cnt16), 32'd0);
    chk("flush_empty", 32'(empty16), 32'd1);
    chk("flush_pulses", 32'({op16, up16}), 32'd0);
    chk("flush_stickies", 32'({os16, us16}), 32'd3);
    cyc(0, 0, 0, 0, 1, 0);
    chk("clr_stickies", 32'({os16, us16}), 32'd0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("clr_vs_err", 32'(us16), 32'd1);
    for (int k = 0; k < 9; k++) cyc(0, 1, 0, 0, 0, 32'h300 + 32'(k));
    cyc(1, 1, 0, 0, 0, 32'h99);
    chk("rst_count", 32'(cnt16), 32'd0);
    chk("rst_flags", 32'({full16, empty16, af16, op16, up16, os16, us16}), 32'b0100000);
    cyc(0, 1, 0, 0, 0, 32'h77);
    chk("post_rst_top", top16, 32'h77);
    chk("post_rst_count", 32'(cnt16), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, k >= 2, 0, 0, 32'h400 + 32'(k));
      if (k >= 2) chk($sformatf("wrap5_top%0d", k), top5, 32'h400 + 32'(k - 1));
    end
    for (int k = 0; k < 3000; k++) begin
      int pp;
      pp = ((k / 300) % 2 == 0) ? 7 : 3;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < pp, $urandom_range(0, 9) >= pp,
          $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_sample_queue.md
Name: sync_sample_queue

Overview:
- Synthesizable, parametrised successor to the testbench-only sample queue.
- Single-clock FIFO between the AXI write-data path and the I2S serializer; also usable as a scoreboard queue in benches.
- Adds first-word-fall-through head output, pop-without-read (drop), flush, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow flags.
- Supports any DEPTH ≥ 2, including non-power-of-two depths.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16384, number of entries (≥ 2; need not be a power of two).
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  enqueue wr_data this cycle.
- wr_data  in  WIDTH  data to enqueue.
- pop  in  1  dequeue/drop the head entry this cycle.
- flush  in  1  synchronous empty without reset of sticky flags.
- clr_err  in  1  clears the sticky overflow/underflow flags.
- top  out  WIDTH  head entry; valid when empty=0.
- count  out  CNT_W  occupancy, 0..DEPTH; CNT_W = $clog2(DEPTH+1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- ovf_pulse  out  1  one-cycle pulse when a push is rejected.
- unf_pulse  out  1  one-cycle pulse when a pop is rejected.
- ovf_sticky  out  1  latched overflow.
- unf_sticky  out  1  latched underflow.

Behaviour:
- Reset (rst=1 at edge):
  - Clears wr_ptr, rd_ptr, count and both sticky and pulse flags.
  - Output values: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - top is don't-care and must not be checked while empty.
  - Reset overrides every other input.
- Pointers:
  - ADDR_W = $clog2(DEPTH).
  - Each pointer wraps to 0 when it would reach DEPTH, by explicit compare, never by natural overflow.
  - count is held in a register, not derived from pointer difference.
- Push:
  - If not full, or full with an accepted pop in the same cycle: write wr_data at wr_ptr, advance wr_ptr.
  - Otherwise drop the data and pulse ovf_pulse for 1 cycle. ovf_sticky=1 from the next cycle.
- Pop:
  - If not empty: advance rd_ptr.
  - If empty: pulse unf_pulse and set unf_sticky. A simultaneous push is still accepted; there is no bypass.
- Count updates:
  - Push only: count+1.
  - Pop only: count−1.
  - Both accepted: unchanged.
  - Flags are registered or derived from the next count, so they are valid in the cycle after the edge.
- top (FWFT):
  - Reflects the head entry in the cycle after it becomes head.
  - Latency from first push on an empty queue to empty=0 and top valid is 1 cycle.
  - Storage may be a registered-output RAM with a head prefetch register; externally observable latency must remain 1.
- flush:
  - Priority over push/pop in the same cycle; both are ignored and no pulses are raised.
  - Sets pointers and count to 0. Sticky flags are unchanged.
- clr_err:
  - Clears both stickies.
  - If an error occurs in the same cycle, the new error wins: the sticky stays 1.
- Reset mid-operation: contents are discarded and there is no partial write.

Decomposition:
- Package sample_queue_pkg holds:
  - function clog2_safe;
  - CNT_W/ADDR_W derivation helpers;
  - a status struct typedef (full, empty, almost_full, almost_empty, ovf, unf) for the serializer and bench.
- One sub-module: sample_queue_ram, a simple dual-port RAM with synchronous write and synchronous read. It is inferred as BRAM for large DEPTH.

Test Plan:
1. DEPTH=16: push 0x00000001..0x00000010 → count=16, full=1, almost_full=1 from count 12. Then pop 16 → top sequence 1..16, empty=1 after the last pop.
2. Full queue, push 0xDEADBEEF alone → ovf_pulse for 1 cycle, ovf_sticky=1, count stays 16. Next 16 pops never return 0xDEADBEEF.
3. DEPTH=5 (non-power-of-two): 12 interleaved push/pop cycles crossing the wrap twice → data order preserved; ptr values never reach 5.
4. Full queue, push+pop same cycle → count stays 16, no ovf_pulse. Empty queue, push 0xA5 + pop → unf_pulse=1, count=1, top=0xA5 next cycle.
5. count=7 with flush+push asserted → count=0, empty=1, no pulses, stickies unchanged. Then clr_err → stickies 0.
6. rst asserted for 1 cycle at count=9 during a push → after reset count=0, empty=1, all flags 0. The first post-reset push appears on top 1 cycle later.
